// File: rtl/otbn_pkg.sv
// Shared OTBN widths plus the DMEM arbiter owner and FSM state encodings.
package otbn_pkg;

  parameter int WLEN             = 256;
  parameter int ExtWLEN          = WLEN * 39 / 32;  // 32-bit words each carry 7 integrity bits
  parameter int BaseWordsPerWLEN = WLEN / 32;

  typedef enum logic [1:0] {
    DmemOwnNone,
    DmemOwnLsu,
    DmemOwnHost
  } dmem_owner_e;

  typedef enum logic [1:0] {
    ArbIdle,
    ArbHostRdWait,
    ArbHostRspHold
  } otbn_dmem_arb_state_e;

endpackage

// File: rtl/otbn_dmem_arb_if.sv
// DMEM request/response bus between the arbiter (master) and the data memory (slave).
interface otbn_dmem_arb_if
  import otbn_pkg::*;
#(
  parameter int AddrWidth = 12
);
  logic                        req;
  logic                        write;
  logic [AddrWidth-1:0]        addr;
  logic [ExtWLEN-1:0]          wdata;
  logic [ExtWLEN-1:0]          wmask;
  logic [BaseWordsPerWLEN-1:0] rmask;
  logic [ExtWLEN-1:0]          rdata;
  logic                        rvalid;
  logic                        rerror;

  modport master (
    output req, write, addr, wdata, wmask, rmask,
    input  rdata, rvalid, rerror
  );

  modport slave (
    input  req, write, addr, wdata, wmask, rmask,
    output rdata, rvalid, rerror
  );
endinterface

// File: rtl/otbn_dmem_arb.sv
// DMEM arbiter: LSU has absolute priority, host uses idle cycles with a held read response.
// Optional host starvation detector enabled by defining OTBN_DMEM_ARB_STARVE_EN.
module otbn_dmem_arb
  import otbn_pkg::*;
#(
  parameter  int DmemSizeByte  = 4096,
  parameter  int StarveThresh  = 64,
  localparam int DmemAddrWidth = $clog2(DmemSizeByte)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,

  input  logic                        lsu_req_i,
  input  logic                        lsu_write_i,
  input  logic [DmemAddrWidth-1:0]    lsu_addr_i,
  input  logic [ExtWLEN-1:0]          lsu_wdata_i,
  input  logic [ExtWLEN-1:0]          lsu_wmask_i,
  input  logic [BaseWordsPerWLEN-1:0] lsu_rmask_i,
  output logic [ExtWLEN-1:0]          lsu_rdata_o,
  output logic                        lsu_rvalid_o,
  output logic                        lsu_rerror_o,

  input  logic                        host_req_i,
  output logic                        host_gnt_o,
  input  logic                        host_write_i,
  input  logic [DmemAddrWidth-1:0]    host_addr_i,
  input  logic [ExtWLEN-1:0]          host_wdata_i,
  input  logic [ExtWLEN-1:0]          host_wmask_i,
  output logic                        host_rvalid_o,
  input  logic                        host_rready_i,
  output logic [ExtWLEN-1:0]          host_rdata_o,
  output logic                        host_rerror_o,

  otbn_dmem_arb_if.master             mem,

  output logic                        rsp_missing_o,
  output logic                        host_starve_o
);

  otbn_dmem_arb_state_e state_q, state_d;
  dmem_owner_e          owner_q, owner_d;
  logic                 rvalid_q, rvalid_d;
  logic [ExtWLEN-1:0]   rdata_q, rdata_d;
  logic                 rerror_q, rerror_d;
  logic                 missing_q, missing_d;

  assign host_gnt_o = host_req_i & ~lsu_req_i & (state_q == ArbIdle);

  always_comb begin
    mem.req   = 1'b0;
    mem.write = 1'b0;
    mem.addr  = '0;
    mem.wdata = '0;
    mem.wmask = '0;
    mem.rmask = '0;
    if (lsu_req_i) begin
      mem.req   = 1'b1;
      mem.write = lsu_write_i;
      mem.addr  = lsu_addr_i;
      mem.wdata = lsu_wdata_i;
      mem.wmask = lsu_wmask_i;
      mem.rmask = lsu_rmask_i;
    end else if (host_gnt_o) begin
      mem.req   = 1'b1;
      mem.write = host_write_i;
      mem.addr  = host_addr_i;
      mem.wdata = host_wdata_i;
      mem.wmask = host_wmask_i;
      mem.rmask = '1;
    end
  end

  // The owner of last cycle's read decides who sees this cycle's mem response.
  always_comb begin
    owner_d = DmemOwnNone;
    if (lsu_req_i && !lsu_write_i) begin
      owner_d = DmemOwnLsu;
    end else if (host_gnt_o && !host_write_i) begin
      owner_d = DmemOwnHost;
    end
  end

  assign lsu_rdata_o  = mem.rdata;
  assign lsu_rvalid_o = mem.rvalid & (owner_q == DmemOwnLsu);
  assign lsu_rerror_o = mem.rerror & lsu_rvalid_o;

  assign missing_d = missing_q | ((owner_q != DmemOwnNone) & ~mem.rvalid);

  always_comb begin
    state_d  = state_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rerror_d = rerror_q;
    unique case (state_q)
      ArbIdle: begin
        if (host_gnt_o && !host_write_i) begin
          state_d = ArbHostRdWait;
        end
      end
      ArbHostRdWait: begin
        // A lost response still completes the host read, flagged as an error.
        rvalid_d = 1'b1;
        rdata_d  = mem.rvalid ? mem.rdata  : '0;
        rerror_d = mem.rvalid ? mem.rerror : 1'b1;
        state_d  = ArbHostRspHold;
      end
      ArbHostRspHold: begin
        if (host_rready_i) begin
          rvalid_d = 1'b0;
          rerror_d = 1'b0;
          state_d  = ArbIdle;
        end
      end
      default: state_d = ArbIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= ArbIdle;
      owner_q   <= DmemOwnNone;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rerror_q  <= 1'b0;
      missing_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rerror_q  <= rerror_d;
      missing_q <= missing_d;
    end
  end

  assign host_rvalid_o = rvalid_q;
  assign host_rdata_o  = rdata_q;
  assign host_rerror_o = rerror_q;
  assign rsp_missing_o = missing_q;

`ifdef OTBN_DMEM_ARB_STARVE_EN
  localparam int CntW = $clog2(StarveThresh + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(StarveThresh);

  logic [CntW-1:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    starve_cnt_d = '0;
    if (host_req_i && !host_gnt_o) begin
      starve_cnt_d = (starve_cnt_q == CntMax) ? starve_cnt_q : starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign host_starve_o = (starve_cnt_q >= CntMax);
`else
  logic unused_starve_thresh;
  assign unused_starve_thresh = ^StarveThresh;
  assign host_starve_o        = 1'b0;
`endif

  a_host_gnt_excl: assert property (@(posedge clk_i) disable iff (!rst_ni)
    host_gnt_o |-> !lsu_req_i);
  a_host_rdata_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (host_rvalid_o && !host_rready_i) |=> $stable(host_rdata_o));

endmodule

// File: tb/tb_otbn_dmem_arb.sv
// Directed bench for otbn_dmem_arb; starvation checks follow OTBN_DMEM_ARB_STARVE_EN.
module tb_otbn_dmem_arb;
  import otbn_pkg::*;

  localparam int AW = 12;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                        lsu_req, lsu_write;
  logic [AW-1:0]               lsu_addr;
  logic [ExtWLEN-1:0]          lsu_wdata, lsu_wmask;
  logic [BaseWordsPerWLEN-1:0] lsu_rmask;
  logic [ExtWLEN-1:0]          lsu_rdata;
  logic                        lsu_rvalid, lsu_rerror;
  logic                        host_req, host_gnt, host_write;
  logic [AW-1:0]               host_addr;
  logic [ExtWLEN-1:0]          host_wdata, host_wmask;
  logic                        host_rvalid, host_rready, host_rerror;
  logic [ExtWLEN-1:0]          host_rdata;
  logic                        rsp_missing, host_starve;

  otbn_dmem_arb_if #(.AddrWidth(AW)) dmem ();

  // Memory stand-in: answers every read one cycle later unless kill is set.
  logic               pend;
  logic               kill;
  logic [ExtWLEN-1:0] rsp_data;
  always @(posedge clk) pend <= dmem.req & ~dmem.write & ~kill;
  assign dmem.rvalid = pend;
  assign dmem.rdata  = rsp_data;
  assign dmem.rerror = 1'b0;

  otbn_dmem_arb #(.DmemSizeByte(4096), .StarveThresh(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .lsu_req_i(lsu_req), .lsu_write_i(lsu_write), .lsu_addr_i(lsu_addr),
    .lsu_wdata_i(lsu_wdata), .lsu_wmask_i(lsu_wmask), .lsu_rmask_i(lsu_rmask),
    .lsu_rdata_o(lsu_rdata), .lsu_rvalid_o(lsu_rvalid), .lsu_rerror_o(lsu_rerror),
    .host_req_i(host_req), .host_gnt_o(host_gnt), .host_write_i(host_write),
    .host_addr_i(host_addr), .host_wdata_i(host_wdata), .host_wmask_i(host_wmask),
    .host_rvalid_o(host_rvalid), .host_rready_i(host_rready),
    .host_rdata_o(host_rdata), .host_rerror_o(host_rerror),
    .mem(dmem),
    .rsp_missing_o(rsp_missing), .host_starve_o(host_starve)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [ExtWLEN-1:0] got,
                       input logic [ExtWLEN-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [ExtWLEN-1:0] d_a5, d_3c, d_69, d_w, ones;

  initial begin
    d_a5 = {39{8'hA5}};
    d_3c = {39{8'h3C}};
    d_69 = {39{8'h69}};
    d_w  = {39{8'h12}};
    ones = '1;
    rst_n = 1'b0; kill = 1'b0; rsp_data = '0;
    lsu_req = 0; lsu_write = 0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0; lsu_rmask = '0;
    host_req = 0; host_write = 0; host_addr = '0; host_wdata = '0; host_wmask = '0;
    host_rready = 0;
    tick(); tick();
    check("rst_host_rvalid", host_rvalid, 0);
    check("rst_host_rdata", host_rdata, 0);
    check("rst_host_rerror", host_rerror, 0);
    check("rst_rsp_missing", rsp_missing, 0);
    check("rst_host_starve", host_starve, 0);
    check("rst_mem_req", dmem.req, 0);
    rst_n = 1'b1;
    tick();

    // LSU read 0x040
    lsu_req = 1; lsu_addr = 12'h040; lsu_rmask = 8'hFF; #2;
    check("lsu_mem_req", dmem.req, 1);
    check("lsu_mem_addr", dmem.addr, 12'h040);
    check("lsu_mem_rmask", dmem.rmask, 8'hFF);
    tick();
    lsu_req = 0; rsp_data = d_a5; #2;
    check("lsu_rvalid", lsu_rvalid, 1);
    check("lsu_rdata", lsu_rdata, d_a5);
    check("lsu_rerror", lsu_rerror, 0);
    check("lsu_no_host_rvalid", host_rvalid, 0);
    tick();

    // Same-cycle LSU read 0x080 and host read 0x100
    lsu_req = 1; lsu_addr = 12'h080; lsu_rmask = 8'h0F;
    host_req = 1; host_write = 0; host_addr = 12'h100; #2;
    check("clash_no_gnt", host_gnt, 0);
    check("clash_mem_addr", dmem.addr, 12'h080);
    tick();
    lsu_req = 0; #2;
    check("clash_lsu_rvalid", lsu_rvalid, 1);
    check("clash_host_gnt", host_gnt, 1);
    check("clash_host_addr", dmem.addr, 12'h100);
    check("clash_host_rmask", dmem.rmask, 8'hFF);
    tick();
    host_req = 0; rsp_data = d_3c; #2;
    check("hrd_wait_rvalid", host_rvalid, 0);
    check("hrd_not_lsu", lsu_rvalid, 0);
    tick();
    rsp_data = '0; #2;
    check("hrd_rvalid", host_rvalid, 1);
    check("hrd_rdata", host_rdata, d_3c);
    check("hrd_rerror", host_rerror, 0);
    host_rready = 1;
    tick();
    host_rready = 0; #2;
    check("hrd_accepted", host_rvalid, 0);

    // Host read 0x104 held for 5 cycles while LSU keeps reading
    host_req = 1; host_addr = 12'h104; #2;
    check("hold_gnt", host_gnt, 1);
    tick();
    host_req = 0; rsp_data = d_69;
    tick();
    rsp_data = '0;
    for (int i = 0; i < 5; i++) begin
      lsu_req = (i % 2 == 0); lsu_addr = 12'(12'h0C0 + i * 4); host_req = 1; #2;
      check("hold_rvalid", host_rvalid, 1);
      check("hold_rdata", host_rdata, d_69);
      check("hold_no_gnt", host_gnt, 0);
      check("hold_lsu_rvalid", lsu_rvalid, (i > 0) && ((i - 1) % 2 == 0));
      tick();
    end
    lsu_req = 0; host_rready = 1; #2;
    check("hold_ready_no_gnt", host_gnt, 0);
    tick();
    host_rready = 0; #2;
    check("hold_regnt", host_gnt, 1);
    check("hold_released", host_rvalid, 0);
    tick();
    host_req = 0;
    tick();
    host_rready = 1;
    tick();
    host_rready = 0;

    // Host write 0x200 full mask
    host_req = 1; host_write = 1; host_addr = 12'h200; host_wdata = d_w; host_wmask = ones; #2;
    check("hwr_gnt", host_gnt, 1);
    check("hwr_mem_write", dmem.write, 1);
    check("hwr_mem_addr", dmem.addr, 12'h200);
    check("hwr_mem_wdata", dmem.wdata, d_w);
    check("hwr_mem_wmask", dmem.wmask, ones);
    tick();
    host_req = 0; #2;
    check("hwr_no_rvalid0", host_rvalid, 0);
    tick();
    check("hwr_no_rvalid1", host_rvalid, 0);

    // Host read with the memory response suppressed
    host_req = 1; host_write = 0; host_addr = 12'h204; kill = 1; rsp_data = d_a5; #2;
    check("miss_gnt_idle", host_gnt, 1);
    tick();
    host_req = 0; kill = 0; #2;
    check("miss_not_yet", rsp_missing, 0);
    tick();
    check("miss_rvalid", host_rvalid, 1);
    check("miss_rerror", host_rerror, 1);
    check("miss_rdata", host_rdata, 0);
    check("miss_flag", rsp_missing, 1);
    host_rready = 1;
    tick();
    host_rready = 0;
    tick();
    check("miss_sticky", rsp_missing, 1);
    rst_n = 0;
    tick();
    rst_n = 1; #2;
    check("miss_cleared", rsp_missing, 0);
    tick();

    // Reset while a host response is held
    host_req = 1; host_addr = 12'h300; rsp_data = d_3c;
    tick();
    host_req = 0;
    tick();
    check("mid_held", host_rvalid, 1);
    rst_n = 0;
    tick();
    rst_n = 1;
    check("mid_dropped", host_rvalid, 0);
    tick();
    check("mid_stays_dropped", host_rvalid, 0);

    // Host write blocked by 6 LSU cycles
    lsu_req = 1; lsu_write = 1; host_req = 1; host_write = 1; host_addr = 12'h208;
    for (int k = 0; k < 6; k++) begin
      #2;
`ifdef OTBN_DMEM_ARB_STARVE_EN
      check("starve_level", host_starve, k >= 4);
`else
      check("starve_off", host_starve, 0);
`endif
      tick();
    end
    lsu_req = 0; #2;
    check("starve_gnt", host_gnt, 1);
    tick();
    host_req = 0; #2;
    check("starve_cleared", host_starve, 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
